// File: rtl/du_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : du_host_ctrl
//  Brief    : Debug-unit master. Decodes host bytes to load, run or step the
//             pipeline, then streams the register file and data memory back.
//  Revision : 1.0  initial release
// ============================================================================
module du_host_ctrl #(
    parameter int NB_DATA        = 32,
    parameter int NB_MEM_ADDR    = 8,
    parameter int NB_REG_ADDR    = 5,
    parameter int MAX_WORDS      = 64,
    parameter int MEM_DUMP_WORDS = 32,
    parameter int RUN_TIMEOUT    = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_pipe_reset,
    output logic [NB_DATA-1:0]     o_du_data,
    output logic [NB_DATA-1:0]     o_du_inst_addr_wr,
    output logic                   o_du_write_en,
    output logic                   o_du_read_en,
    output logic [NB_REG_ADDR-1:0] o_du_reg_addr,
    output logic [NB_MEM_ADDR-1:0] o_du_mem_addr,
    input  logic                   i_du_halt,
    input  logic [NB_DATA-1:0]     i_du_regs_data,
    input  logic [NB_DATA-1:0]     i_du_mem_data,
    output logic                   o_busy
);

    localparam int C_ST_W = 4;
    localparam logic [C_ST_W-1:0] S_IDLE       = 4'd0;
    localparam logic [C_ST_W-1:0] S_LOAD_N     = 4'd1;
    localparam logic [C_ST_W-1:0] S_LOAD_BYTES = 4'd2;
    localparam logic [C_ST_W-1:0] S_RUN        = 4'd3;
    localparam logic [C_ST_W-1:0] S_STEP       = 4'd4;
    localparam logic [C_ST_W-1:0] S_DUMP_ADDR  = 4'd5;
    localparam logic [C_ST_W-1:0] S_DUMP_WAIT  = 4'd6;
    localparam logic [C_ST_W-1:0] S_DUMP_CAP   = 4'd7;
    localparam logic [C_ST_W-1:0] S_DUMP_TX    = 4'd8;
    localparam logic [C_ST_W-1:0] S_TX_WAIT    = 4'd9;
    localparam logic [C_ST_W-1:0] S_ACK        = 4'd10;

    localparam logic [7:0] C_CMD_LOAD = 8'h4C;
    localparam logic [7:0] C_CMD_RUN  = 8'h52;
    localparam logic [7:0] C_CMD_STEP = 8'h53;
    localparam logic [7:0] C_CMD_DUMP = 8'h44;
    localparam logic [7:0] C_ACK      = 8'h06;
    localparam logic [7:0] C_NAK      = 8'h15;

    localparam logic [7:0] C_MAX_WORDS = 8'(MAX_WORDS);
    localparam logic [7:0] C_REG_LAST  = 8'((1 << NB_REG_ADDR) - 1);
    localparam logic [7:0] C_MEM_LAST  = 8'(MEM_DUMP_WORDS - 1);
    localparam int         C_TO_W      = $clog2(RUN_TIMEOUT + 1);
    localparam logic [C_TO_W-1:0] C_TIMEOUT = C_TO_W'(RUN_TIMEOUT);

    logic [C_ST_W-1:0]     r_state;
    logic [C_ST_W-1:0]     r_ret;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_pipe_reset;
    logic                  r_write_en;
    logic [NB_DATA-1:0]    r_du_data;
    logic [NB_DATA-1:0]    r_inst_addr;
    logic [NB_REG_ADDR-1:0] r_reg_addr;
    logic [NB_MEM_ADDR-1:0] r_mem_addr;
    logic [7:0]            r_nwords;
    logic [7:0]            r_word_idx;
    logic [1:0]            r_byte_cnt;
    logic [NB_DATA-9:0]    r_word_sr;
    logic [C_TO_W-1:0]     r_timeout;
    logic [7:0]            r_idx;
    logic                  r_dump_mem;
    logic [NB_DATA-1:0]    r_dump_sr;
    logic                  w_read_en;

    // Run enable is gated by halt combinationally so the pipeline never advances past HALT.
    assign w_read_en = (((r_state == S_RUN) && (r_timeout != C_TIMEOUT)) || (r_state == S_STEP))
                       && !i_du_halt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_ret        <= S_IDLE;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_pipe_reset <= 1'b0;
            r_write_en   <= 1'b0;
            r_du_data    <= '0;
            r_inst_addr  <= '0;
            r_reg_addr   <= '0;
            r_mem_addr   <= '0;
            r_nwords     <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_word_sr    <= '0;
            r_timeout    <= '0;
            r_idx        <= '0;
            r_dump_mem   <= 1'b0;
            r_dump_sr    <= '0;
        end else begin
            r_pipe_reset <= 1'b0;
            r_write_en   <= 1'b0;
            if (r_tx_valid && i_tx_ready)
                r_tx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            C_CMD_LOAD: begin
                                r_pipe_reset <= 1'b1;
                                r_state      <= S_LOAD_N;
                            end
                            C_CMD_RUN: begin
                                r_timeout <= '0;
                                r_state   <= S_RUN;
                            end
                            C_CMD_STEP: r_state <= S_STEP;
                            C_CMD_DUMP: begin
                                r_idx      <= '0;
                                r_dump_mem <= 1'b0;
                                r_state    <= S_DUMP_ADDR;
                            end
                            default: begin
                                r_tx_data  <= C_NAK;
                                r_tx_valid <= 1'b1;
                                r_ret      <= S_IDLE;
                                r_state    <= S_TX_WAIT;
                            end
                        endcase
                    end
                end
                S_LOAD_N: begin
                    if (i_rx_valid) begin
                        if ((i_rx_data == 8'd0) || (i_rx_data > C_MAX_WORDS)) begin
                            r_tx_data  <= C_NAK;
                            r_tx_valid <= 1'b1;
                            r_ret      <= S_IDLE;
                            r_state    <= S_TX_WAIT;
                        end else begin
                            r_nwords   <= i_rx_data;
                            r_word_idx <= '0;
                            r_byte_cnt <= '0;
                            r_state    <= S_LOAD_BYTES;
                        end
                    end
                end
                S_LOAD_BYTES: begin
                    if (i_rx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_write_en  <= 1'b1;
                            r_du_data   <= {r_word_sr, i_rx_data};
                            r_inst_addr <= {{(NB_DATA-10){1'b0}}, r_word_idx, 2'b00};
                            r_word_idx  <= r_word_idx + 8'd1;
                            if (r_word_idx == (r_nwords - 8'd1)) begin
                                r_tx_data  <= C_ACK;
                                r_tx_valid <= 1'b1;
                                r_ret      <= S_IDLE;
                                r_state    <= S_TX_WAIT;
                            end
                        end else begin
                            r_word_sr <= {r_word_sr[NB_DATA-17:0], i_rx_data};
                        end
                    end
                end
                S_RUN: begin
                    if (i_du_halt) begin
                        r_idx      <= '0;
                        r_dump_mem <= 1'b0;
                        r_state    <= S_DUMP_ADDR;
                    end else if (r_timeout == C_TIMEOUT) begin
                        r_tx_data  <= C_NAK;
                        r_tx_valid <= 1'b1;
                        r_idx      <= '0;
                        r_dump_mem <= 1'b0;
                        r_ret      <= S_DUMP_ADDR;
                        r_state    <= S_TX_WAIT;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                S_STEP: begin
                    r_idx      <= '0;
                    r_dump_mem <= 1'b0;
                    r_state    <= S_DUMP_ADDR;
                end
                S_DUMP_ADDR: begin
                    r_reg_addr <= r_idx[NB_REG_ADDR-1:0];
                    r_mem_addr <= {r_idx[NB_MEM_ADDR-3:0], 2'b00};
                    r_state    <= S_DUMP_WAIT;
                end
                S_DUMP_WAIT: r_state <= S_DUMP_CAP;
                S_DUMP_CAP: begin
                    r_dump_sr  <= r_dump_mem ? i_du_mem_data : i_du_regs_data;
                    r_byte_cnt <= '0;
                    r_state    <= S_DUMP_TX;
                end
                S_DUMP_TX: begin
                    r_tx_data  <= r_dump_sr[NB_DATA-1 -: 8];
                    r_dump_sr  <= r_dump_sr << 8;
                    r_tx_valid <= 1'b1;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_state    <= S_TX_WAIT;
                    if (r_byte_cnt != 2'd3) begin
                        r_ret <= S_DUMP_TX;
                    end else if (r_dump_mem && (r_idx == C_MEM_LAST)) begin
                        r_ret <= S_ACK;
                    end else begin
                        r_ret <= S_DUMP_ADDR;
                        if (!r_dump_mem && (r_idx == C_REG_LAST)) begin
                            r_dump_mem <= 1'b1;
                            r_idx      <= '0;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                S_ACK: begin
                    r_tx_data  <= C_ACK;
                    r_tx_valid <= 1'b1;
                    r_ret      <= S_IDLE;
                    r_state    <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (r_tx_valid && i_tx_ready)
                        r_state <= r_ret;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_data         = r_tx_data;
    assign o_tx_valid        = r_tx_valid;
    assign o_pipe_reset      = r_pipe_reset;
    assign o_du_data         = r_du_data;
    assign o_du_inst_addr_wr = r_inst_addr;
    assign o_du_write_en     = r_write_en;
    assign o_du_read_en      = w_read_en;
    assign o_du_reg_addr     = r_reg_addr;
    assign o_du_mem_addr     = r_mem_addr;
    assign o_busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire
